h264_enc_cfg_sequencer: RTL and testbench

AXI4-Lite master that programs the H264 I-frame encoder's configuration registers: QP at 0x0C, HRES at 0x18, VRES at 0x1C, ENABLE at 0x04.
- Runs the full programming sequence once after reset, using parameter defaults.
- Runs it again on each host reconfiguration request, but only inside vertical blanking so a frame is never split across two configurations.
- Gates the pixel-side frame-start pulse to the encoder while programming is in progress.
- Sits between the system timing generator/host and the encoder's AXI slave port. In this integration the encoder's ACLK_I is driven by SYSCLK.

---
 rtl/h264_enc_cfg_pkg.sv | 31 +++
 rtl/h264_axil_wr_master.sv | 90 +++++++++
 rtl/h264_enc_cfg_sequencer.sv | 157 +++++++++++++++
 tb/tb_h264_enc_cfg_sequencer.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h264_enc_cfg_pkg.sv
// Shared types and register map for the H264 encoder configuration sequencer.
// Holds the encoder register offsets, the sequencer and write-engine states, and the entry index type.
package h264_enc_cfg_pkg;

    localparam logic [31:0] REG_ENABLE = 32'h04;
    localparam logic [31:0] REG_QP     = 32'h0C;
    localparam logic [31:0] REG_HRES   = 32'h18;
    localparam logic [31:0] REG_VRES   = 32'h1C;

    localparam int unsigned QP_MAX    = 51;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef logic [2:0] entry_idx_t;
    localparam entry_idx_t LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        S_WAIT_START,
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_AW,
        E_W,
        E_B
    } wr_state_t;

endpackage

// File: rtl/h264_axil_wr_master.sv
// Single AXI4-Lite write engine: AW, then W, then B, with a per-phase timeout.
// Valids are decoded from the registered state, so they fall as soon as reset asserts.
module h264_axil_wr_master
    import h264_enc_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        SYSCLK,
    input  logic        NSYSRESET,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        done,
    output logic        err,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    wr_state_t   st;
    wr_state_t   st_nxt;
    logic [15:0] tmo_cnt;
    logic        hs;
    logic        tmo;

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            st      <= E_IDLE;
            tmo_cnt <= '0;
            awaddr  <= '0;
            wdata   <= '0;
        end else begin
            st <= st_nxt;
            if (st_nxt != st || st_nxt == E_IDLE)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 16'd1;
            if (start && st == E_IDLE) begin
                awaddr <= addr;
                wdata  <= data;
            end
        end
    end

    always_comb begin
        hs = 1'b0;
        unique case (st)
            E_AW:    hs = awready;
            E_W:     hs = wready;
            E_B:     hs = bvalid;
            default: hs = 1'b0;
        endcase
    end

    assign tmo = (st != E_IDLE) && !hs && (tmo_cnt == TMO_LAST);

    always_comb begin
        st_nxt = st;
        unique case (st)
            E_IDLE: if (start) st_nxt = E_AW;
            E_AW: begin
                if (awready)  st_nxt = E_W;
                else if (tmo) st_nxt = E_IDLE;
            end
            E_W: begin
                if (wready)   st_nxt = E_B;
                else if (tmo) st_nxt = E_IDLE;
            end
            E_B: if (bvalid || tmo) st_nxt = E_IDLE;
            default: st_nxt = E_IDLE;
        endcase
    end

    always_comb begin
        awvalid = (st == E_AW);
        wvalid  = (st == E_W);
        bready  = (st == E_B);
        done    = (st == E_B) && bvalid && (bresp == RESP_OKAY);
        err     = tmo || ((st == E_B) && bvalid && (bresp != RESP_OKAY));
    end

endmodule

// File: rtl/h264_enc_cfg_sequencer.sv
// Programs the encoder's QP/HRES/VRES/ENABLE registers at power-up and on host
// request (applied only in vblank), and gates frame starts while programming.
module h264_enc_cfg_sequencer
    import h264_enc_cfg_pkg::*;
#(
    parameter int unsigned DEF_QP    = 10,
    parameter int unsigned DEF_HRES  = 224,
    parameter int unsigned DEF_VRES  = 224,
    parameter int unsigned START_DLY = 50,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        SYSCLK,
    input  logic        NSYSRESET,
    input  logic        cfg_req_i,
    input  logic [5:0]  cfg_qp_i,
    input  logic [15:0] cfg_hres_i,
    input  logic [15:0] cfg_vres_i,
    output logic        cfg_ack_o,
    output logic        cfg_rej_o,
    input  logic        vblank_i,
    input  logic        frame_start_i,
    output logic        frame_start_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [7:0]  drop_cnt_o,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [15:0] DLY_LAST = 16'(START_DLY - 1);

    seq_state_t  state;
    seq_state_t  state_nxt;
    entry_idx_t  idx;
    logic [15:0] dly_cnt;
    logic        pending;
    logic [5:0]  qp_r;
    logic [15:0] hres_r;
    logic [15:0] vres_r;
    logic        start;
    logic        wr_done;
    logic        wr_err;
    logic [31:0] ent_addr;
    logic [31:0] ent_data;
    logic        req_bad;

    // Resolutions must be non-zero multiples of a macroblock (16 pixels).
    assign req_bad = (cfg_qp_i > 6'(QP_MAX))
                   || (cfg_hres_i == '0) || (cfg_hres_i[3:0] != '0)
                   || (cfg_vres_i == '0) || (cfg_vres_i[3:0] != '0)
                   || pending || busy_o;

    assign frame_start_o = frame_start_i & ~busy_o;

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) state <= S_WAIT_START;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_WAIT_START: if (dly_cnt == DLY_LAST) state_nxt = S_ISSUE;
            S_IDLE:       if (pending && vblank_i) state_nxt = S_ISSUE;
            S_ISSUE:      state_nxt = S_XFER;
            S_XFER: begin
                if (wr_err)       state_nxt = S_IDLE;
                else if (wr_done) state_nxt = (idx == LAST_IDX) ? S_DONE : S_ISSUE;
            end
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start    = (state == S_ISSUE);
        ent_addr = REG_ENABLE;
        ent_data = '0;
        unique case (idx)
            3'd0: begin ent_addr = REG_ENABLE; ent_data = 32'd0;            end
            3'd1: begin ent_addr = REG_QP;     ent_data = {26'b0, qp_r};    end
            3'd2: begin ent_addr = REG_HRES;   ent_data = {16'b0, hres_r};  end
            3'd3: begin ent_addr = REG_VRES;   ent_data = {16'b0, vres_r};  end
            default: begin ent_addr = REG_ENABLE; ent_data = 32'd1;         end
        endcase
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            dly_cnt    <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            qp_r       <= 6'(DEF_QP);
            hres_r     <= 16'(DEF_HRES);
            vres_r     <= 16'(DEF_VRES);
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
            cfg_ack_o  <= 1'b0;
            cfg_rej_o  <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            busy_o    <= (state_nxt != S_IDLE);
            cfg_ack_o <= (state_nxt == S_DONE);
            cfg_rej_o <= cfg_req_i && req_bad;
            if (state == S_WAIT_START)
                dly_cnt <= dly_cnt + 16'd1;
            // Power-up starts at the QP entry: the encoder is not yet enabled.
            if (state == S_WAIT_START && state_nxt == S_ISSUE)
                idx <= 3'd1;
            else if (state == S_IDLE && state_nxt == S_ISSUE)
                idx <= 3'd0;
            else if (state == S_XFER && wr_done && idx != LAST_IDX)
                idx <= idx + 3'd1;
            if (cfg_req_i && !req_bad) begin
                pending <= 1'b1;
                qp_r    <= cfg_qp_i;
                hres_r  <= cfg_hres_i;
                vres_r  <= cfg_vres_i;
            end else if (state == S_IDLE && state_nxt == S_ISSUE) begin
                pending <= 1'b0;
            end
            if (wr_err)
                err_o <= 1'b1;
            if (frame_start_i && busy_o && drop_cnt_o != 8'hFF)
                drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end

    h264_axil_wr_master #(
        .TIMEOUT (TIMEOUT)
    ) u_wr (
        .SYSCLK    (SYSCLK),
        .NSYSRESET (NSYSRESET),
        .start     (start),
        .addr      (ent_addr),
        .data      (ent_data),
        .done      (wr_done),
        .err       (wr_err),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

endmodule

// File: tb/tb_h264_enc_cfg_sequencer.sv
// Directed bench for the encoder configuration sequencer with a simple
// AXI4-Lite slave whose ready signals and response are steered per scenario.
module tb_h264_enc_cfg_sequencer;

    logic        SYSCLK = 1'b0;
    logic        NSYSRESET = 1'b0;
    logic        cfg_req_i = 1'b0;
    logic [5:0]  cfg_qp_i = '0;
    logic [15:0] cfg_hres_i = '0;
    logic [15:0] cfg_vres_i = '0;
    logic        cfg_ack_o;
    logic        cfg_rej_o;
    logic        vblank_i = 1'b0;
    logic        frame_start_i = 1'b0;
    logic        frame_start_o;
    logic        busy_o;
    logic        err_o;
    logic [7:0]  drop_cnt_o;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic aw_en = 1'b1;
    logic w_en = 1'b1;
    logic bresp_bad = 1'b0;

    int checks = 0;
    int fails = 0;
    int ack_cnt = 0;
    int rej_cnt = 0;
    int fso_cnt = 0;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    always #5 SYSCLK = ~SYSCLK;

    assign awready = aw_en;
    assign wready  = w_en;
    assign bvalid  = bready;
    assign bresp   = (bresp_bad && awaddr == 32'h0C) ? 2'b10 : 2'b00;

    h264_enc_cfg_sequencer dut (
        .SYSCLK        (SYSCLK),
        .NSYSRESET     (NSYSRESET),
        .cfg_req_i     (cfg_req_i),
        .cfg_qp_i      (cfg_qp_i),
        .cfg_hres_i    (cfg_hres_i),
        .cfg_vres_i    (cfg_vres_i),
        .cfg_ack_o     (cfg_ack_o),
        .cfg_rej_o     (cfg_rej_o),
        .vblank_i      (vblank_i),
        .frame_start_i (frame_start_i),
        .frame_start_o (frame_start_o),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .drop_cnt_o    (drop_cnt_o),
        .awaddr        (awaddr),
        .awvalid       (awvalid),
        .awready       (awready),
        .wdata         (wdata),
        .wvalid        (wvalid),
        .wready        (wready),
        .bresp         (bresp),
        .bvalid        (bvalid),
        .bready        (bready)
    );

    always @(posedge SYSCLK) begin
        if (awvalid && awready) log_addr.push_back(awaddr);
        if (wvalid && wready)   log_data.push_back(wdata);
        if (cfg_ack_o)     ack_cnt++;
        if (cfg_rej_o)     rej_cnt++;
        if (frame_start_o) fso_cnt++;
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic send_req(input logic [5:0] qp, input logic [15:0] h, input logic [15:0] v);
        cfg_req_i  = 1'b1;
        cfg_qp_i   = qp;
        cfg_hres_i = h;
        cfg_vres_i = v;
        @(negedge SYSCLK);
        cfg_req_i  = 1'b0;
    endtask

    task automatic wait_busy(input string nm, input int lim);
        int n = 0;
        while (!busy_o && n < lim) begin @(negedge SYSCLK); n++; end
        checks++;
        if (!busy_o) begin
            fails++;
            $display("FAIL %s_busy_wait: busy_o=0 after %0d cycles, want 1", nm, lim);
        end
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int n = 0;
        while (busy_o && n < lim) begin @(negedge SYSCLK); n++; end
        checks++;
        if (busy_o) begin
            fails++;
            $display("FAIL %s_idle_wait: busy_o=1 after %0d cycles, want 0", nm, lim);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic test_reset();
        logic early = 1'b0;
        NSYSRESET = 1'b0;
        clk_n(3);
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b000) begin
            fails++;
            $display("FAIL rst_valids: got %b want 000", {awvalid, wvalid, bready});
        end
        checks++;
        if ({busy_o, err_o, cfg_ack_o, cfg_rej_o} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_flags: got %b want 0000", {busy_o, err_o, cfg_ack_o, cfg_rej_o});
        end
        checks++;
        if (drop_cnt_o !== 8'd0 || awaddr !== 32'd0 || wdata !== 32'd0) begin
            fails++;
            $display("FAIL rst_regs: drop=%0h awaddr=%0h wdata=%0h want 0", drop_cnt_o, awaddr, wdata);
        end
        NSYSRESET = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge SYSCLK);
            if (awvalid) early = 1'b1;
        end
        checks++;
        if (early || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL start_delay: early_aw=%b busy=%b want 0/1", early, busy_o);
        end
    endtask

    task automatic test_powerup();
        logic [31:0] ea [4] = '{32'h0C, 32'h18, 32'h1C, 32'h04};
        logic [31:0] ed [4] = '{32'h0A, 32'hE0, 32'hE0, 32'h01};
        wait_idle("pwr", 200);
        checks++;
        if (log_addr.size() != 4 || log_data.size() != 4) begin
            fails++;
            $display("FAIL pwr_count: got %0d writes want 4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
                    fails++;
                    $display("FAIL pwr_wr%0d: got %0h=%0h want %0h=%0h", i, log_addr[i], log_data[i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (ack_cnt != 1) begin
            fails++;
            $display("FAIL pwr_ack: got %0d want 1", ack_cnt);
        end
    endtask

    task automatic test_vblank_req();
        logic [31:0] ea [5] = '{32'h04, 32'h0C, 32'h18, 32'h1C, 32'h04};
        logic [31:0] ed [5] = '{32'h00, 32'h14, 32'h140, 32'hF0, 32'h01};
        int ack0 = ack_cnt;
        int rej0 = rej_cnt;
        clear_log();
        vblank_i = 1'b0;
        send_req(6'd20, 16'd320, 16'd240);
        clk_n(20);
        checks++;
        if (log_addr.size() != 0 || busy_o !== 1'b0 || rej_cnt != rej0) begin
            fails++;
            $display("FAIL vb_hold: writes=%0d busy=%b rej=%0d want 0/0/%0d", log_addr.size(), busy_o, rej_cnt, rej0);
        end
        vblank_i = 1'b1;
        wait_busy("vb", 10);
        wait_idle("vb", 100);
        vblank_i = 1'b0;
        checks++;
        if (log_addr.size() != 5 || log_data.size() != 5) begin
            fails++;
            $display("FAIL vb_count: got %0d writes want 5", log_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
                    fails++;
                    $display("FAIL vb_wr%0d: got %0h=%0h want %0h=%0h", i, log_addr[i], log_data[i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (ack_cnt != ack0 + 1) begin
            fails++;
            $display("FAIL vb_ack: got %0d want %0d", ack_cnt, ack0 + 1);
        end
    endtask

    task automatic test_latency();
        int n = 1;
        vblank_i = 1'b1;
        send_req(6'd10, 16'd224, 16'd224);
        while (!awvalid && n < 10) begin @(negedge SYSCLK); n++; end
        checks++;
        if (n != 3) begin
            fails++;
            $display("FAIL req_latency: got %0d cycles want 3", n);
        end
        wait_idle("lat", 100);
        vblank_i = 1'b0;
    endtask

    task automatic test_invalid();
        logic [31:0] ed [5] = '{32'h00, 32'h10, 32'hB0, 32'h90, 32'h01};
        int rej0 = rej_cnt;
        clear_log();
        vblank_i = 1'b1;
        send_req(6'd52, 16'd224, 16'd224);
        clk_n(2);
        checks++;
        if (rej_cnt != rej0 + 1) begin
            fails++;
            $display("FAIL rej_qp: got %0d want %0d", rej_cnt, rej0 + 1);
        end
        send_req(6'd10, 16'd100, 16'd224);
        clk_n(2);
        checks++;
        if (rej_cnt != rej0 + 2) begin
            fails++;
            $display("FAIL rej_hres: got %0d want %0d", rej_cnt, rej0 + 2);
        end
        send_req(6'd10, 16'd224, 16'd0);
        clk_n(5);
        checks++;
        if (rej_cnt != rej0 + 3 || log_addr.size() != 0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL rej_vres: rej=%0d writes=%0d busy=%b want %0d/0/0", rej_cnt, log_addr.size(), busy_o, rej0 + 3);
        end
        vblank_i = 1'b0;
        send_req(6'd16, 16'd176, 16'd144);
        send_req(6'd30, 16'd48, 16'd48);
        clk_n(1);
        checks++;
        if (rej_cnt != rej0 + 4) begin
            fails++;
            $display("FAIL rej_pending: got %0d want %0d", rej_cnt, rej0 + 4);
        end
        vblank_i = 1'b1;
        wait_busy("inv", 10);
        send_req(6'd40, 16'd64, 16'd64);
        wait_idle("inv", 100);
        vblank_i = 1'b0;
        checks++;
        if (rej_cnt != rej0 + 5) begin
            fails++;
            $display("FAIL rej_busy: got %0d want %0d", rej_cnt, rej0 + 5);
        end
        checks++;
        if (log_data.size() != 5) begin
            fails++;
            $display("FAIL rej_count: got %0d writes want 5", log_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_data[i] !== ed[i]) begin
                    fails++;
                    $display("FAIL rej_shadow%0d: got %0h want %0h", i, log_data[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_frame_gate();
        int fso0 = fso_cnt;
        checks++;
        if (drop_cnt_o !== 8'd0) begin
            fails++;
            $display("FAIL drop_init: got %0d want 0", drop_cnt_o);
        end
        vblank_i = 1'b1;
        send_req(6'd10, 16'd224, 16'd224);
        wait_busy("fs", 10);
        for (int i = 0; i < 3; i++) begin
            frame_start_i = 1'b1;
            #1;
            checks++;
            if (frame_start_o !== 1'b0) begin
                fails++;
                $display("FAIL fs_gated%0d: got %b want 0", i, frame_start_o);
            end
            @(negedge SYSCLK);
            frame_start_i = 1'b0;
            @(negedge SYSCLK);
        end
        wait_idle("fs", 100);
        vblank_i = 1'b0;
        frame_start_i = 1'b1;
        #1;
        checks++;
        if (frame_start_o !== 1'b1) begin
            fails++;
            $display("FAIL fs_pass: got %b want 1", frame_start_o);
        end
        @(negedge SYSCLK);
        frame_start_i = 1'b0;
        clk_n(2);
        checks++;
        if (fso_cnt != fso0 + 1 || drop_cnt_o !== 8'd3) begin
            fails++;
            $display("FAIL fs_count: fso=%0d drop=%0d want %0d/3", fso_cnt - fso0, drop_cnt_o, 1);
        end
    endtask

    task automatic test_timeout();
        int ack0 = ack_cnt;
        int n_aw = 0;
        int k = 0;
        checks++;
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL tmo_err_pre: got %b want 0", err_o);
        end
        clear_log();
        aw_en = 1'b0;
        vblank_i = 1'b1;
        send_req(6'd10, 16'd224, 16'd224);
        wait_busy("tmo", 10);
        while (busy_o && k < 400) begin
            if (awvalid) n_aw++;
            @(negedge SYSCLK);
            k++;
        end
        checks++;
        if (n_aw != 255 || awvalid !== 1'b0) begin
            fails++;
            $display("FAIL tmo_aw: aw_cycles=%0d awvalid=%b want 255/0", n_aw, awvalid);
        end
        checks++;
        if (err_o !== 1'b1 || ack_cnt != ack0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL tmo_err: err=%b acks=%0d busy=%b want 1/%0d/0", err_o, ack_cnt, busy_o, ack0);
        end
        clk_n(45);
        aw_en = 1'b1;
        send_req(6'd10, 16'd224, 16'd224);
        wait_busy("tmo2", 10);
        wait_idle("tmo2", 100);
        vblank_i = 1'b0;
        checks++;
        if (ack_cnt != ack0 + 1 || err_o !== 1'b1 || log_addr.size() != 5) begin
            fails++;
            $display("FAIL tmo_recover: acks=%0d err=%b writes=%0d want %0d/1/5", ack_cnt, err_o, log_addr.size(), ack0 + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int ack0;
        w_en = 1'b0;
        vblank_i = 1'b1;
        send_req(6'd10, 16'd224, 16'd224);
        while (!wvalid && n < 20) begin @(negedge SYSCLK); n++; end
        checks++;
        if (!wvalid) begin
            fails++;
            $display("FAIL mid_wvalid: got 0 want 1 within 20 cycles");
        end
        #1 NSYSRESET = 1'b0;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, busy_o, err_o} !== 5'b00000 || drop_cnt_o !== 8'd0) begin
            fails++;
            $display("FAIL mid_async: got %b drop=%0d want 00000/0", {awvalid, wvalid, bready, busy_o, err_o}, drop_cnt_o);
        end
        @(negedge SYSCLK);
        vblank_i = 1'b0;
        w_en = 1'b1;
        clear_log();
        ack0 = ack_cnt;
        NSYSRESET = 1'b1;
        clk_n(50);
        checks++;
        if (log_addr.size() != 0) begin
            fails++;
            $display("FAIL mid_delay: got %0d writes want 0", log_addr.size());
        end
        wait_idle("mid", 100);
        checks++;
        if (log_addr.size() != 4 || log_data.size() != 4) begin
            fails++;
            $display("FAIL mid_count: got %0d writes want 4", log_addr.size());
        end else if (log_addr[0] !== 32'h0C || log_data[0] !== 32'h0A
                     || log_addr[3] !== 32'h04 || log_data[3] !== 32'h01) begin
            fails++;
            $display("FAIL mid_order: got %0h=%0h..%0h=%0h want c=a..4=1", log_addr[0], log_data[0], log_addr[3], log_data[3]);
        end
        checks++;
        if (ack_cnt != ack0 + 1) begin
            fails++;
            $display("FAIL mid_ack: got %0d want %0d", ack_cnt, ack0 + 1);
        end
    endtask

    task automatic test_bresp();
        int ack0 = ack_cnt;
        checks++;
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL br_err_pre: got %b want 0", err_o);
        end
        clear_log();
        bresp_bad = 1'b1;
        vblank_i = 1'b1;
        send_req(6'd10, 16'd224, 16'd224);
        wait_busy("br", 10);
        wait_idle("br", 100);
        bresp_bad = 1'b0;
        vblank_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || ack_cnt != ack0) begin
            fails++;
            $display("FAIL br_err: err=%b acks=%0d want 1/%0d", err_o, ack_cnt, ack0);
        end
        checks++;
        if (log_addr.size() != 2) begin
            fails++;
            $display("FAIL br_abort: got %0d writes want 2", log_addr.size());
        end else if (log_addr[1] !== 32'h0C) begin
            fails++;
            $display("FAIL br_last: got %0h want c", log_addr[1]);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_vblank_req();
        test_latency();
        test_invalid();
        test_frame_gate();
        test_timeout();
        test_reset_mid();
        test_bresp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
